axi_traffic_gen: RTL
====================

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, AXI data width; ID_WIDTH, default 5, AXI ID width; ADDR_WIDTH, default 16, AXI address width.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a run; honoured only in IDLE.
- wr_nrd  in  1  run type, sampled at start: 1 = write bursts, 0 = read bursts.
- cfg_id  in  ID_WIDTH  AWID/ARID for the run.
- cfg_base  in  ADDR_WIDTH  first burst address.
- cfg_len  in  8  AxLEN; beats per burst = cfg_len+1.
- cfg_num  in  16  bursts per run; 0 = finish immediately.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- err  out  1  sticky protocol-check flag, cleared at start.
- cycles  out  32  aclk cycles from start to done.
- beats  out  32  completed data beats (W or R handshakes).
- AW channel: awvalid/awid/awaddr/awlen/awsize/awburst out, awready in.
- W channel: wvalid/wdata/wstrb/wlast out, wready in.
- B channel: bid in, bvalid in, bready out.
- AR channel: arvalid/arid/araddr/arlen/arsize/arburst out, arready in.
- R channel: rid/rdata/rlast/rvalid in, rready out.
- Widths: AXI ID fields ID_WIDTH; addresses ADDR_WIDTH; WDATA/RDATA DATA_WIDTH; WSTRB DATA_WIDTH/8; AxLEN 8; AxSIZE 3; AxBURST 2.

Function
REQ-003 The FSM SHALL have states IDLE, AW, W, B, AR, R, FIN.
REQ-004 IDLE SHALL go on start to AW if wr_nrd=1 and to AR if wr_nrd=0, to FIN if cfg_num=0, latching all cfg_* inputs and clearing cycles, beats and err.
REQ-005 AW SHALL hold awvalid=1 with stable fields until awready, then go to W.
REQ-006 W SHALL drive one beat per wvalid&&wready handshake, with wlast=1 on beat cfg_len, then go to B.
REQ-007 B SHALL hold bready=1; on bvalid, it SHALL go to AW for the next burst, or to FIN after burst cfg_num-1.
REQ-008 AR SHALL mirror AW, going to R on arready.
REQ-009 R SHALL hold rready=1; on the beat with rlast=1, it SHALL go to AR for the next burst, or to FIN after the final burst.
REQ-010 FIN SHALL assert done for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-011 Exactly one burst SHALL be outstanding at a time; AW and W SHALL never be concurrently valid.
REQ-012 Burst addresses SHALL be cfg_base + k*(cfg_len+1) for burst index k, computed modulo 2^ADDR_WIDTH so they wrap.
REQ-013 AxSIZE SHALL be log2(DATA_WIDTH/8), AxBURST SHALL be 2'b01 (INCR), and WSTRB SHALL be all ones.
REQ-014 wdata SHALL equal the low DATA_WIDTH bits of beats, so the pattern is a running counter across the run.
REQ-015 The counter beats SHALL increment on each W or R handshake; cycles SHALL increment on every cycle while busy, including the FIN cycle.
REQ-016 Both counters SHALL wrap at 2^32 without flagging.
REQ-017 err SHALL set when bid != cfg_id on a B handshake, when rid != cfg_id on an R handshake, when rlast=1 before beat cfg_len, or when rlast=0 on beat cfg_len.
REQ-018 On early rlast, the burst SHALL be treated as complete; on a missing rlast, the FSM SHALL stay in R until rlast arrives.
REQ-019 start while busy SHALL be ignored.
REQ-020 Beats SHALL be counted only on valid&&ready; valid SHALL never depend on ready.

Reset
REQ-021 Asserting aresetn low SHALL immediately force state to IDLE and clear all valid/ready outputs, busy, done, err, cycles and beats, even mid-burst.
REQ-022 On reset, address/ID/data outputs SHALL be driven to 0.
REQ-023 After aresetn rises, the first start SHALL be accepted no earlier than the following rising edge.

Verification
REQ-024 Write run, cfg_base=0x0100, cfg_len=3, cfg_num=2, slave always ready -> AWADDR 0x0100 then 0x0104, wdata 0..7, wlast on beats 3 and 7, beats=8, done pulse, err=0.
REQ-025 Read run, cfg_len=0, cfg_num=4, cfg_id=5, RAM slave -> 4 single-beat reads, beats=4, err=0; repeat with slave returning rid=6 -> err=1.
REQ-026 Address wrap: cfg_base=0xFFFE, cfg_len=1, cfg_num=2 -> AWADDR 0xFFFE then 0x0000.
REQ-027 Backpressure: randomised awready, wready and bvalid stalls -> all fields held stable while valid, beats=(cfg_len+1)*cfg_num, cycles equals the measured busy duration.
REQ-028 aresetn pulled low during W beat 2 -> all outputs 0 on the next edge; a new start after release runs cleanly from cfg_base.
REQ-029 cfg_num=0 -> done exactly 2 cycles after start, no AXI valid asserted.

Source files
------------

// File: rtl/axi_traffic_gen.sv
// AXI traffic generator: runs a sequence of INCR write or read bursts, one burst
// outstanding at a time, with cycle/beat counters and a sticky protocol-check flag.
module axi_traffic_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    wr_nrd,
    input  logic [ID_WIDTH-1:0]     cfg_id,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [7:0]              cfg_len,
    input  logic [15:0]             cfg_num,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             cycles,
    output logic [31:0]             beats,
    output logic                    awvalid,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    input  logic                    awready,
    output logic                    wvalid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    arvalid,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     id_reg;
    logic [7:0]              len_reg;
    logic [15:0]             num_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [15:0]             burst_cnt;
    logic [7:0]              beat_idx;

    logic [31:0]             beats_inc;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    last_burst;

    assign awsize  = 3'($clog2(DATA_WIDTH/8));
    assign arsize  = 3'($clog2(DATA_WIDTH/8));
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = '1;

    // Next burst starts (len+1) beats further on; truncation gives the address wrap.
    assign beats_inc  = beats + 32'd1;
    assign addr_next  = addr_reg + ADDR_WIDTH'({1'b0, len_reg} + 9'd1);
    assign last_burst = (burst_cnt == num_reg - 16'd1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            id_reg    <= '0;
            len_reg   <= '0;
            num_reg   <= '0;
            addr_reg  <= '0;
            burst_cnt <= '0;
            beat_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cycles    <= '0;
            beats     <= '0;
            awvalid   <= 1'b0;
            awid      <= '0;
            awaddr    <= '0;
            awlen     <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wlast     <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            arid      <= '0;
            araddr    <= '0;
            arlen     <= '0;
            rready    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                cycles <= cycles + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        id_reg    <= cfg_id;
                        len_reg   <= cfg_len;
                        num_reg   <= cfg_num;
                        addr_reg  <= cfg_base;
                        burst_cnt <= '0;
                        cycles    <= '0;
                        beats     <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        if (cfg_num == 16'd0) begin
                            state <= FIN;
                        end else if (wr_nrd) begin
                            state   <= AW;
                            awvalid <= 1'b1;
                            awid    <= cfg_id;
                            awaddr  <= cfg_base;
                            awlen   <= cfg_len;
                        end else begin
                            state   <= AR;
                            arvalid <= 1'b1;
                            arid    <= cfg_id;
                            araddr  <= cfg_base;
                            arlen   <= cfg_len;
                        end
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        wvalid   <= 1'b1;
                        wdata    <= DATA_WIDTH'(beats);
                        wlast    <= (len_reg == 8'd0);
                        beat_idx <= '0;
                        state    <= W;
                    end
                end
                W: begin
                    if (wvalid && wready) begin
                        beats <= beats_inc;
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            beat_idx <= beat_idx + 8'd1;
                            wdata    <= DATA_WIDTH'(beats_inc);
                            wlast    <= (beat_idx + 8'd1 == len_reg);
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bid != id_reg) begin
                            err <= 1'b1;
                        end
                        if (last_burst) begin
                            state <= FIN;
                        end else begin
                            burst_cnt <= burst_cnt + 16'd1;
                            addr_reg  <= addr_next;
                            awaddr    <= addr_next;
                            awvalid   <= 1'b1;
                            state     <= AW;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        beat_idx <= '0;
                        state    <= R;
                    end
                end
                R: begin
                    if (rvalid && rready) begin
                        beats <= beats_inc;
                        if (rid != id_reg) begin
                            err <= 1'b1;
                        end
                        // rlast ends the burst even when early; without it we keep accepting beats.
                        if (rlast) begin
                            if (beat_idx != len_reg) begin
                                err <= 1'b1;
                            end
                            rready <= 1'b0;
                            if (last_burst) begin
                                state <= FIN;
                            end else begin
                                burst_cnt <= burst_cnt + 16'd1;
                                addr_reg  <= addr_next;
                                araddr    <= addr_next;
                                arvalid   <= 1'b1;
                                state     <= AR;
                            end
                        end else begin
                            if (beat_idx == len_reg) begin
                                err <= 1'b1;
                            end
                            beat_idx <= beat_idx + 8'd1;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
